cayde_decode_stage: RTL and testbench

CAYDE_DECODE_STAGE -- requirements
Module: cayde_decode_stage

---
 rtl/cayde_pkg.sv | 44 ++++
 rtl/cayde_decode_comb.sv | 66 ++++++
 rtl/cayde_decode_stage.sv | 106 ++++++++++
 tb/tb_cayde_decode_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cayde_pkg.sv
// cayde_pkg: ALU operation codes, opcode/funct7 constants and funct3 mapping shared by the decode stage
package cayde_pkg;

    typedef enum logic [6:0] {
        ALU_ADD    = 7'd0,
        ALU_SUB    = 7'd1,
        ALU_XOR    = 7'd2,
        ALU_AND    = 7'd3,
        ALU_OR     = 7'd4,
        ALU_SLL    = 7'd5,
        ALU_SLT    = 7'd6,
        ALU_SLTU   = 7'd7,
        ALU_SRL    = 7'd8,
        ALU_SRA    = 7'd9,
        ALU_MUL    = 7'd16,
        ALU_MULH   = 7'd17,
        ALU_MULHSU = 7'd18,
        ALU_MULHU  = 7'd19,
        ALU_DIV    = 7'd20,
        ALU_DIVU   = 7'd21,
        ALU_REM    = 7'd22,
        ALU_REMU   = 7'd23
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Base-ISA operation selected by funct3 when funct7 is the plain encoding
    function automatic alu_op_e f3_op(input logic [2:0] f3);
        return (f3 == 3'b000) ? ALU_ADD  :
               (f3 == 3'b001) ? ALU_SLL  :
               (f3 == 3'b010) ? ALU_SLT  :
               (f3 == 3'b011) ? ALU_SLTU :
               (f3 == 3'b100) ? ALU_XOR  :
               (f3 == 3'b101) ? ALU_SRL  :
               (f3 == 3'b110) ? ALU_OR   : ALU_AND;
    endfunction

endpackage

// File: rtl/cayde_decode_comb.sv
// cayde_decode_comb: purely combinational RV32I/M subset decoder (instruction -> control fields)
module cayde_decode_comb
    import cayde_pkg::*;
#(
    parameter int ENABLE_M = 0
) (
    input  logic [31:0] i_instr,
    output alu_op_e     o_alu_op,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [31:0] o_imm,
    output logic        o_use_imm,
    output logic        o_reg_we,
    output logic        o_illegal
);

    logic [6:0] w_opc;
    logic [6:0] w_f7;
    logic [2:0] w_f3;
    logic       w_shift;

    assign w_opc   = i_instr[6:0];
    assign w_f7    = i_instr[31:25];
    assign w_f3    = i_instr[14:12];
    assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    // Everything defaults to the illegal encoding; each recognised form overrides it.
    // Opcode comparison includes instr[1:0], so non-32-bit encodings fall through as illegal.
    always_comb begin
        o_alu_op  = ALU_ADD;
        o_rs1     = i_instr[19:15];
        o_rs2     = i_instr[24:20];
        o_rd      = i_instr[11:7];
        o_imm     = '0;
        o_use_imm = 1'b0;
        o_reg_we  = 1'b0;
        o_illegal = 1'b1;
        if (w_opc == OPC_OP) begin
            if (w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                o_alu_op  = (w_f7 == F7_ALT) ? ((w_f3 == 3'b000) ? ALU_SUB : ALU_SRA) : f3_op(w_f3);
                o_reg_we  = 1'b1;
                o_illegal = 1'b0;
            end else if (ENABLE_M != 0 && w_f7 == F7_MULDIV) begin
                o_alu_op  = alu_op_e'({4'b0010, w_f3});
                o_reg_we  = 1'b1;
                o_illegal = 1'b0;
            end
        end else if (w_opc == OPC_OP_IMM) begin
            if (!w_shift || w_f7 == F7_BASE || (w_f3 == 3'b101 && w_f7 == F7_ALT)) begin
                o_alu_op  = (w_shift && w_f7 == F7_ALT) ? ALU_SRA : f3_op(w_f3);
                o_imm     = {{20{i_instr[31]}}, i_instr[31:20]};
                o_use_imm = 1'b1;
                o_reg_we  = 1'b1;
                o_illegal = 1'b0;
            end
        end else if (w_opc == OPC_LUI) begin
            o_rs1     = '0;
            o_imm     = {i_instr[31:12], 12'b0};
            o_use_imm = 1'b1;
            o_reg_we  = 1'b1;
            o_illegal = 1'b0;
        end
    end

endmodule

// File: rtl/cayde_decode_stage.sv
// cayde_decode_stage: one-deep registered decode stage with valid/ready handshake and illegal counter
module cayde_decode_stage
    import cayde_pkg::*;
#(
    parameter int ENABLE_M = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_op_e          alu_op,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [31:0]      imm,
    output logic             use_imm,
    output logic             reg_we,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    alu_op_e          w_alu_op;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_rd;
    logic [31:0]      w_imm;
    logic             w_use_imm;
    logic             w_reg_we;
    logic             w_illegal;
    logic             w_accept;

    logic             r_valid;
    alu_op_e          r_alu_op;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [31:0]      r_imm;
    logic             r_use_imm;
    logic             r_reg_we;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    cayde_decode_comb #(.ENABLE_M(ENABLE_M)) u_comb (
        .i_instr   (in_instr),
        .o_alu_op  (w_alu_op),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_rd      (w_rd),
        .o_imm     (w_imm),
        .o_use_imm (w_use_imm),
        .o_reg_we  (w_reg_we),
        .o_illegal (w_illegal)
    );

    // Flush blocks acceptance so a flushed instruction is neither held nor counted
    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Output register: loads on acceptance, drains on consumption, clears on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_alu_op  <= ALU_ADD;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
            r_reg_we  <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_alu_op  <= w_alu_op;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_imm     <= w_imm;
            r_use_imm <= w_use_imm;
            r_reg_we  <= w_reg_we;
            r_illegal <= w_illegal;
            if (w_illegal && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign alu_op      = r_alu_op;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign imm         = r_imm;
    assign use_imm     = r_use_imm;
    assign reg_we      = r_reg_we;
    assign illegal     = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_cayde_decode_stage.sv
// tb_cayde_decode_stage: directed checks of the decode stage (default, ENABLE_M=1 and CNT_W=2 builds)
module tb_cayde_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;

    logic        in_ready, out_valid, use_imm, reg_we, illegal;
    logic [6:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [7:0]  cnt;

    logic        in_ready_m, out_valid_m, use_imm_m, reg_we_m, illegal_m;
    logic [6:0]  alu_op_m;
    logic [4:0]  rs1_m, rs2_m, rd_m;
    logic [31:0] imm_m;
    logic [7:0]  cnt_m;

    logic        in_ready_c, out_valid_c, use_imm_c, reg_we_c, illegal_c;
    logic [6:0]  alu_op_c;
    logic [4:0]  rs1_c, rs2_c, rd_c;
    logic [31:0] imm_c;
    logic [1:0]  cnt_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cayde_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm), .reg_we(reg_we),
        .illegal(illegal), .illegal_cnt(cnt)
    );

    cayde_decode_stage #(.ENABLE_M(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_instr(in_instr), .out_valid(out_valid_m), .out_ready(out_ready), .alu_op(alu_op_m),
        .rs1(rs1_m), .rs2(rs2_m), .rd(rd_m), .imm(imm_m), .use_imm(use_imm_m), .reg_we(reg_we_m),
        .illegal(illegal_m), .illegal_cnt(cnt_m)
    );

    cayde_decode_stage #(.CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_instr(in_instr), .out_valid(out_valid_c), .out_ready(out_ready), .alu_op(alu_op_c),
        .rs1(rs1_c), .rs2(rs2_c), .rd(rd_c), .imm(imm_c), .use_imm(use_imm_c), .reg_we(reg_we_c),
        .illegal(illegal_c), .illegal_cnt(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy);
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 32'h002081B3, 1'b1);
        chk("add_in_ready", 32'(in_ready), 32'd1);
        tick;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_alu", 32'(alu_op), 32'd0);
        chk("add_rs1", 32'(rs1), 32'd1);
        chk("add_rs2", 32'(rs2), 32'd2);
        chk("add_rd", 32'(rd), 32'd3);
        chk("add_we", 32'(reg_we), 32'd1);
        chk("add_use_imm", 32'(use_imm), 32'd0);
        chk("add_illegal", 32'(illegal), 32'd0);

        drive(1'b1, 32'h40208133, 1'b1);
        tick;
        chk("sub_alu", 32'(alu_op), 32'd1);
        chk("sub_rd", 32'(rd), 32'd2);
        drive(1'b1, 32'hFFF00093, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_alu", 32'(alu_op), 32'd1);
            chk("stall_rd", 32'(rd), 32'd2);
            chk("stall_rs1", 32'(rs1), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(in_ready), 32'd1);
        tick;
        chk("addi_alu", 32'(alu_op), 32'd0);
        chk("addi_use_imm", 32'(use_imm), 32'd1);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_rd", 32'(rd), 32'd1);
        chk("addi_rs1", 32'(rs1), 32'd0);
        chk("addi_we", 32'(reg_we), 32'd1);

        drive(1'b1, 32'h02208133, 1'b1);
        tick;
        chk("mul0_illegal", 32'(illegal), 32'd1);
        chk("mul0_we", 32'(reg_we), 32'd0);
        chk("mul0_alu", 32'(alu_op), 32'd0);
        chk("mul0_imm", imm, 32'd0);
        chk("mul0_cnt", 32'(cnt), 32'd1);
        chk("mul1_alu", 32'(alu_op_m), 32'd16);
        chk("mul1_illegal", 32'(illegal_m), 32'd0);
        chk("mul1_we", 32'(reg_we_m), 32'd1);
        chk("mul1_cnt", 32'(cnt_m), 32'd0);
        chk("mulc_cnt", 32'(cnt_c), 32'd1);

        drive(1'b1, 32'h40335293, 1'b1);
        tick;
        chk("srai_alu", 32'(alu_op), 32'd9);
        chk("srai_imm", imm, 32'h00000403);
        chk("srai_use_imm", 32'(use_imm), 32'd1);
        chk("srai_rs1", 32'(rs1), 32'd6);
        chk("srai_rd", 32'(rd), 32'd5);
        chk("srai_illegal", 32'(illegal), 32'd0);

        drive(1'b1, 32'h40331293, 1'b1);
        tick;
        chk("badslli_illegal", 32'(illegal), 32'd1);
        chk("badslli_cnt", 32'(cnt), 32'd2);

        drive(1'b1, 32'h123453B7, 1'b1);
        tick;
        chk("lui_alu", 32'(alu_op), 32'd0);
        chk("lui_rs1", 32'(rs1), 32'd0);
        chk("lui_imm", imm, 32'h12345000);
        chk("lui_use_imm", 32'(use_imm), 32'd1);
        chk("lui_we", 32'(reg_we), 32'd1);
        chk("lui_rd", 32'(rd), 32'd7);
        chk("lui_illegal", 32'(illegal), 32'd0);

        drive(1'b1, 32'h00000001, 1'b1);
        tick;
        chk("cmp16_illegal", 32'(illegal), 32'd1);
        chk("cmp16_cnt", 32'(cnt), 32'd3);
        chk("cmp16_cnt_c", 32'(cnt_c), 32'd3);

        drive(1'b1, 32'h00208033, 1'b1);
        tick;
        chk("rd0_rd", 32'(rd), 32'd0);
        chk("rd0_we", 32'(reg_we), 32'd1);

        drive(1'b1, 32'h0020B1B3, 1'b1);
        tick;
        chk("sltu_alu", 32'(alu_op), 32'd7);

        drive(1'b0, 32'h0, 1'b1);
        tick;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);

        drive(1'b1, 32'h00000001, 1'b0);
        tick;
        chk("ill4_valid", 32'(out_valid), 32'd1);
        chk("ill4_cnt", 32'(cnt), 32'd4);
        chk("sat_cnt_c", 32'(cnt_c), 32'd3);

        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_cnt", 32'(cnt), 32'd4);
        flush = 1'b0;

        drive(1'b1, 32'h002081B3, 1'b0);
        tick;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick;
        chk("pre_rst_stall", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_we", 32'(reg_we), 32'd0);
        chk("arst_rd", 32'(rd), 32'd0);
        chk("arst_rs1", 32'(rs1), 32'd0);
        chk("arst_rs2", 32'(rs2), 32'd0);
        chk("arst_imm", imm, 32'd0);
        chk("arst_alu", 32'(alu_op), 32'd0);
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_illegal", 32'(illegal), 32'd0);
        chk("arst_use_imm", 32'(use_imm), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 32'h00000001, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("post_rst_valid", 32'(out_valid), 32'd1);
            chk("post_rst_cnt", 32'(cnt), 32'(i));
            chk("cntw2_cnt", 32'(cnt_c), (i > 3) ? 32'd3 : 32'(i));
        end
        in_valid = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
